// File: rtl/chroni_mem_arbiter.sv
// chroni_mem_arbiter
//   Shares the single 8-bit system memory port between CHRONI video fetch,
//   the CPU and a DMA/blitter engine. Video has fixed priority, but a streak
//   cap stops it from starving the others. CPU and DMA alternate when both
//   are pending. A wait timeout stops a dead memory from hanging the bus.
//   Every access takes the path IDLE -> WAIT -> DONE -> IDLE.
//
// Ports
//   sys_clk, reset            clock; synchronous active-high reset
//   vid_req/vid_addr/vid_page video read request and its {page, addr}
//   vid_ack/vid_rdata         video completion pulse and read data
//   cpu_*/dma_*               request, write enable, 21-bit address, write
//                             data; completion pulse and read data back
//   mem_req/mem_we/mem_addr/mem_wdata  access to memory, held during WAIT
//   mem_rdata/mem_ack         memory read data and completion pulse
//   grant                     owner of the current access (0 none, 1 vid,
//                             2 cpu, 3 dma)
//   timeout_err               sticky flag, set when any access times out
module chroni_mem_arbiter #(
  parameter int unsigned VID_MAX_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  input  logic [7:0]  vid_page,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [20:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_DMA  = 2'd3;

  localparam logic [3:0] STREAK_CAP = 4'(VID_MAX_STREAK);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [3:0]  streak;
  logic [7:0]  wcnt;
  // 1 when DMA was the last CPU/DMA grant, so CPU wins the next tie.
  logic        rr_dma_last;

  logic [1:0]  pick;
  logic [20:0] pick_addr;
  logic        pick_we;
  logic [7:0]  pick_wdata;
  logic        vid_blocked;
  logic        finish;
  logic [7:0]  finish_data;

  function automatic logic [3:0] streak_sat_inc(input logic [3:0] cur);
    if (cur < STREAK_CAP) return cur + 4'd1;
    else                  return cur;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pick        = GNT_NONE;
    pick_addr   = '0;
    pick_we     = 1'b0;
    pick_wdata  = '0;
    finish      = 1'b0;
    finish_data = '0;
    // Video yields only once it has hit the cap and someone else is waiting.
    vid_blocked = (streak == STREAK_CAP) && (cpu_req || dma_req);

    case (state)
      ST_IDLE: begin
        if (vid_req && !vid_blocked)  pick = GNT_VID;
        else if (cpu_req && dma_req)  pick = rr_dma_last ? GNT_CPU : GNT_DMA;
        else if (cpu_req)             pick = GNT_CPU;
        else if (dma_req)             pick = GNT_DMA;

        case (pick)
          GNT_VID: pick_addr = {vid_page, vid_addr};
          GNT_CPU: begin
            pick_addr  = cpu_addr;
            pick_we    = cpu_we;
            pick_wdata = cpu_wdata;
          end
          GNT_DMA: begin
            pick_addr  = dma_addr;
            pick_we    = dma_we;
            pick_wdata = dma_wdata;
          end
          default: ;
        endcase

        if (pick != GNT_NONE) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack arriving on the timeout cycle still counts as success.
        if (mem_ack) begin
          finish      = 1'b1;
          finish_data = mem_we ? 8'h00 : mem_rdata;
          state_next  = ST_DONE;
        end else if (wcnt == WAIT_LIMIT) begin
          finish      = 1'b1;
          finish_data = TIMEOUT_DATA;
          state_next  = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant       <= GNT_NONE;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      vid_rdata   <= '0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      streak      <= '0;
      wcnt        <= '0;
      timeout_err <= 1'b0;
      rr_dma_last <= 1'b1;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      // IDLE -> WAIT: launch the winner's access.
      if (state == ST_IDLE && pick != GNT_NONE) begin
        mem_req   <= 1'b1;
        mem_we    <= pick_we;
        mem_addr  <= pick_addr;
        mem_wdata <= pick_wdata;
        grant     <= pick;
        wcnt      <= '0;
        if (pick == GNT_VID) begin
          streak <= streak_sat_inc(streak);
        end else begin
          streak      <= '0;
          rr_dma_last <= (pick == GNT_DMA);
        end
      end

      // WAIT -> DONE: complete or abort, ack the owner next cycle.
      if (state == ST_WAIT) begin
        if (finish) begin
          mem_req <= 1'b0;
          if (!mem_ack) timeout_err <= 1'b1;
          case (grant)
            GNT_VID: begin
              vid_ack   <= 1'b1;
              vid_rdata <= finish_data;
            end
            GNT_CPU: begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= finish_data;
            end
            GNT_DMA: begin
              dma_ack   <= 1'b1;
              dma_rdata <= finish_data;
            end
            default: ;
          endcase
        end else begin
          wcnt <= wcnt + 8'd1;
        end
      end

      // DONE -> IDLE: release ownership.
      if (state == ST_DONE) grant <= GNT_NONE;
    end
  end

endmodule
